// File: rtl/mips_mem_pkg.sv
// Shared types and field indices for the MEM stage of the 5-stage MIPS pipeline.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;

    localparam logic [1:0] WB_BUBBLE = 2'b00;

endpackage

// File: rtl/dmem_bus_ctrl.sv
// Data-memory request controller: IDLE/BUSY/DONE FSM, ack timeout and the
// registers that hold the in-flight instruction until it leaves the stage.
module dmem_bus_ctrl
    import mips_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_W-1:0]  wrreg_i,
    input  logic [1:0]        wb_i,
    input  logic [1:0]        m_i,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output mem_state_e        state_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] addr_hold_o,
    output logic [REG_W-1:0]  wrreg_hold_o,
    output logic [1:0]        wb_hold_o,
    output logic              bus_err_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [REG_W-1:0]  wrreg_q, wrreg_d;
    logic [1:0]        wb_q, wb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;

    // Next-state logic; dmem_addr doubles as the ALU-result hold register.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wrreg_d   = wrreg_q;
        wb_d      = wb_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    req_d   = 1'b1;
                    we_d    = m_i[M_WRITE];
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wrreg_d = wrreg_i;
                    wb_d    = wb_i;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dmem_ack_i) begin
                    rdata_d = we_q ? {DATA_W{1'b0}} : dmem_rdata_i;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = {DATA_W{1'b0}};
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    wb_d      = WB_BUBBLE;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request/hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= {DATA_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            rdata_q   <= {DATA_W{1'b0}};
            wrreg_q   <= {REG_W{1'b0}};
            wb_q      <= 2'b00;
            cnt_q     <= {CNT_W{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wrreg_q   <= wrreg_d;
            wb_q      <= wb_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign state_o      = state_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign rdata_o      = rdata_q;
    assign addr_hold_o  = addr_q;
    assign wrreg_hold_o = wrreg_q;
    assign wb_hold_o    = wb_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream while one
// is outstanding and drives the MEM/WB-bound fields (bubbles while stalled).
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [REG_W-1:0]  WrReg,
    input  logic [1:0]        WB,
    input  logic [1:0]        M,
    output logic              stall,
    output logic [DATA_W-1:0] MemOp,
    output logic [DATA_W-1:0] ResultRType,
    output logic [REG_W-1:0]  WrRegOut,
    output logic [1:0]        WBOut,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              misalign,
    output logic              bus_err
);

    mem_state_e        state_s;
    logic              memop_s;
    logic              start_s;
    logic [DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0] addr_hold_s;
    logic [REG_W-1:0]  wrreg_hold_s;
    logic [1:0]        wb_hold_s;
    logic [1:0]        wb_pass_s;

    assign memop_s   = in_valid & (M[M_READ] | M[M_WRITE]);
    assign misalign  = memop_s & (ALUResult[1:0] != 2'b00);
    assign start_s   = (state_s == ST_IDLE) & memop_s & ~misalign;
    assign wb_pass_s = {WB[WB_REGWRITE], WB[WB_MEMTOREG]};

    dmem_bus_ctrl #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT)
    ) u_bus (
        .clk          (clk),
        .rst_n        (reset),
        .start_i      (start_s),
        .addr_i       (ALUResult),
        .wdata_i      (StoreData),
        .wrreg_i      (WrReg),
        .wb_i         (WB),
        .m_i          (M),
        .dmem_ack_i   (dmem_ack),
        .dmem_rdata_i (dmem_rdata),
        .state_o      (state_s),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .rdata_o      (rdata_s),
        .addr_hold_o  (addr_hold_s),
        .wrreg_hold_o (wrreg_hold_s),
        .wb_hold_o    (wb_hold_s),
        .bus_err_o    (bus_err)
    );

    // MEM/WB field muxing: pass-through in IDLE, bubble in BUSY, held result in DONE.
    always_comb begin
        stall       = 1'b0;
        MemOp       = {DATA_W{1'b0}};
        ResultRType = ALUResult;
        WrRegOut    = WrReg;
        WBOut       = WB_BUBBLE;
        case (state_s)
            ST_IDLE: begin
                stall = start_s;
                WBOut = (in_valid & ~memop_s) ? wb_pass_s : WB_BUBBLE;
            end
            ST_BUSY: begin
                stall       = 1'b1;
                ResultRType = addr_hold_s;
                WrRegOut    = wrreg_hold_s;
            end
            ST_DONE: begin
                MemOp       = rdata_s;
                ResultRType = addr_hold_s;
                WrRegOut    = wrreg_hold_s;
                WBOut       = wb_hold_s;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule
